// File: rtl/pipeline_execute_pkg.sv
// Shared encodings for the execute stage: ALU op codes, MEM op codes,
// the multiplier FSM states and the E-stage control bundle.
package pipeline_execute_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;
    localparam logic [3:0] ALU_MULHU = 4'd12;

    localparam logic [3:0] MEM_LB  = 4'd0;
    localparam logic [3:0] MEM_LH  = 4'd1;
    localparam logic [3:0] MEM_LW  = 4'd2;
    localparam logic [3:0] MEM_LBU = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_SB  = 4'd5;
    localparam logic [3:0] MEM_SH  = 4'd6;
    localparam logic [3:0] MEM_SW  = 4'd7;
    localparam logic [3:0] NO_MEM  = 4'd15;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic       regWriteEn;
        logic [1:0] resultSrc;
        logic       memWriteEn;
        logic [3:0] memOpType;
        logic [3:0] aluOp;
    } ex_ctrl_t;

    function automatic ex_ctrl_t ctrl_bubble();
        ex_ctrl_t c;
        c.regWriteEn = 1'b0;
        c.resultSrc  = 2'd0;
        c.memWriteEn = 1'b0;
        c.memOpType  = NO_MEM;
        c.aluOp      = ALU_ADD;
        return c;
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/pipeline_execute_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// full double-width product held in the accumulator while in DONE.
module mul_iterative
    import pipeline_execute_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] product_o
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        if (abort_i) begin
            state_d = MUL_IDLE;
            count_d = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                MUL_IDLE: if (start_i) begin
                    mcand_d = {{XLEN{1'b0}}, a_i};
                    mplr_d  = b_i;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = MUL_BUSY;
                end
                MUL_BUSY: begin
                    if (mplr_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    if (count_q == CW'(MUL_CYCLES - 1)) begin
                        count_d = '0;
                        state_d = MUL_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                MUL_DONE: state_d = MUL_IDLE;
                default:  state_d = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MUL_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
        end
    end

    assign busy_o    = (state_q != MUL_IDLE);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = acc_q;

endmodule

// File: rtl/pipeline_execute.sv
// RV32 execute stage: ID/EX register, single-cycle ALU and an iterative
// multiplier that stalls decode and bubbles MEM until its product is ready.
module pipeline_execute
    import pipeline_execute_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            validD,
    input  logic            flushE,
    input  logic            regWriteEnD,
    input  logic [1:0]      resultSrcD,
    input  logic            memWriteEnD,
    input  logic [3:0]      memOpTypeD,
    input  logic [3:0]      aluOpD,
    input  logic [XLEN-1:0] srcAD,
    input  logic [XLEN-1:0] srcBD,
    input  logic [XLEN-1:0] memWriteDataD,
    output logic            regWriteEnE,
    output logic [1:0]      resultSrcE,
    output logic            memWriteEnE,
    output logic [3:0]      memOpTypeE,
    output logic [XLEN-1:0] aluResultE,
    output logic [XLEN-1:0] memWriteDataE,
    output logic            stallD,
    output logic            mulBusyE
);
    ex_ctrl_t          ctrl_q, ctrl_d;
    logic [XLEN-1:0]   srcA_q, srcA_d;
    logic [XLEN-1:0]   srcB_q, srcB_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              mul_busy, mul_done, mul_start, mul_held;
    logic [2*XLEN-1:0] product;
    logic [4:0]        shamt;

    // A multiply sitting in E with the FSM idle has not launched yet and still stalls.
    assign mul_held  = is_mul_op(ctrl_q.aluOp);
    assign stallD    = mul_busy ? !mul_done : mul_held;
    assign mul_start = !mul_busy && mul_held && !flushE;
    assign mulBusyE  = mul_busy;

    mul_iterative #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .abort_i   (flushE),
        .a_i       (srcA_q),
        .b_i       (srcB_q),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (product)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        srcA_d  = srcA_q;
        srcB_d  = srcB_q;
        wdata_d = wdata_q;
        if (flushE || (!stallD && !validD)) begin
            ctrl_d  = ctrl_bubble();
            srcA_d  = '0;
            srcB_d  = '0;
            wdata_d = '0;
        end else if (!stallD) begin
            ctrl_d.regWriteEn = regWriteEnD;
            ctrl_d.resultSrc  = resultSrcD;
            ctrl_d.memWriteEn = memWriteEnD;
            ctrl_d.memOpType  = memOpTypeD;
            ctrl_d.aluOp      = aluOpD;
            srcA_d            = srcAD;
            srcB_d            = srcBD;
            wdata_d           = memWriteDataD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= ctrl_bubble();
            srcA_q  <= '0;
            srcB_q  <= '0;
            wdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            srcA_q  <= srcA_d;
            srcB_q  <= srcB_d;
            wdata_q <= wdata_d;
        end
    end

    assign shamt = srcB_q[4:0];

    always_comb begin
        aluResultE = '0;
        unique case (ctrl_q.aluOp)
            ALU_ADD:   aluResultE = srcA_q + srcB_q;
            ALU_SUB:   aluResultE = srcA_q - srcB_q;
            ALU_SLL:   aluResultE = srcA_q << shamt;
            ALU_SLT:   aluResultE = {{(XLEN-1){1'b0}}, $signed(srcA_q) < $signed(srcB_q)};
            ALU_SLTU:  aluResultE = {{(XLEN-1){1'b0}}, srcA_q < srcB_q};
            ALU_XOR:   aluResultE = srcA_q ^ srcB_q;
            ALU_SRL:   aluResultE = srcA_q >> shamt;
            ALU_SRA:   aluResultE = XLEN'($signed(srcA_q) >>> shamt);
            ALU_OR:    aluResultE = srcA_q | srcB_q;
            ALU_AND:   aluResultE = srcA_q & srcB_q;
            ALU_PASSB: aluResultE = srcB_q;
            ALU_MUL:   aluResultE = mul_done ? product[XLEN-1:0] : '0;
            ALU_MULHU: aluResultE = mul_done ? product[2*XLEN-1:XLEN] : '0;
            default:   aluResultE = '0;
        endcase
    end

    // MEM only ever sees a bubble while the multiplier owns the stage.
    assign regWriteEnE   = ctrl_q.regWriteEn & ~stallD;
    assign memWriteEnE   = ctrl_q.memWriteEn & ~stallD;
    assign memOpTypeE    = stallD ? NO_MEM : ctrl_q.memOpType;
    assign resultSrcE    = ctrl_q.resultSrc;
    assign memWriteDataE = wdata_q;

endmodule

// File: tb/tb_pipeline_execute.sv
// Directed bench for pipeline_execute: ALU ops, store pass-through, multiply
// latency and bubbling, flush and reset aborts of a running multiply.
module tb_pipeline_execute;
    import pipeline_execute_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        validD, flushE, regWriteEnD, memWriteEnD;
    logic [1:0]  resultSrcD;
    logic [3:0]  memOpTypeD, aluOpD;
    logic [31:0] srcAD, srcBD, memWriteDataD;
    logic        regWriteEnE, memWriteEnE, stallD, mulBusyE;
    logic [1:0]  resultSrcE;
    logic [3:0]  memOpTypeE;
    logic [31:0] aluResultE, memWriteDataE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_execute dut (
        .clk(clk), .reset(reset), .validD(validD), .flushE(flushE),
        .regWriteEnD(regWriteEnD), .resultSrcD(resultSrcD), .memWriteEnD(memWriteEnD),
        .memOpTypeD(memOpTypeD), .aluOpD(aluOpD), .srcAD(srcAD), .srcBD(srcBD),
        .memWriteDataD(memWriteDataD), .regWriteEnE(regWriteEnE), .resultSrcE(resultSrcE),
        .memWriteEnE(memWriteEnE), .memOpTypeE(memOpTypeE), .aluResultE(aluResultE),
        .memWriteDataE(memWriteDataE), .stallD(stallD), .mulBusyE(mulBusyE)
    );

    task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [3:0] mop, input logic [3:0] aop,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd);
        validD = v; regWriteEnD = rw; resultSrcD = rs; memWriteEnD = mw;
        memOpTypeD = mop; aluOpD = aop; srcAD = a; srcBD = b; memWriteDataD = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances while stalled, counting stall cycles and any non-bubble leaking to MEM.
    task automatic wait_stall(output int n, output int leaks);
        n = 0;
        leaks = 0;
        while (stallD && n < 200) begin
            if (regWriteEnE || memWriteEnE || memOpTypeE !== NO_MEM) leaks++;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flushE = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd0, 32'd0, 32'd0);
        #2;
        checks++;
        if (regWriteEnE !== 1'b0 || memWriteEnE !== 1'b0 || memOpTypeE !== NO_MEM ||
            aluResultE !== 32'd0 || stallD !== 1'b0 || mulBusyE !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: rw=%b mw=%b mop=%h res=%h stall=%b busy=%b", regWriteEnE,
                     memWriteEnE, memOpTypeE, aluResultE, stallD, mulBusyE);
        end
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 2'd1, 1'b0, MEM_LW, ALU_ADD, 32'd100, 32'd23, 32'h55);
        tick();
        checks++;
        if (aluResultE !== 32'd123 || regWriteEnE !== 1'b1 || memOpTypeE !== MEM_LW ||
            resultSrcE !== 2'd1) begin
            errors++;
            $display("FAIL reset_pre: res=%h rw=%b mop=%h rs=%0d expected 0000007b 1 2 1",
                     aluResultE, regWriteEnE, memOpTypeE, resultSrcE);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (regWriteEnE !== 1'b0 || memOpTypeE !== NO_MEM || aluResultE !== 32'd0 ||
            memWriteDataE !== 32'd0 || resultSrcE !== 2'd0 || stallD !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rw=%b mop=%h res=%h wd=%h rs=%0d stall=%b", regWriteEnE,
                     memOpTypeE, aluResultE, memWriteDataE, resultSrcE, stallD);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_alu();
        logic [3:0]  ops [10] = '{ALU_ADD, ALU_SRA, ALU_SLTU, ALU_SLT, ALU_SUB,
                                  ALU_SLL, ALU_SRL, ALU_XOR, ALU_PASSB, ALU_AND};
        logic [31:0] as  [10] = '{32'h7fffffff, 32'h80000000, 32'd1, 32'hffffffff, 32'd0,
                                  32'd1, 32'h80000000, 32'hff00ff00, 32'hdeadbeef, 32'hf0f0_1234};
        logic [31:0] bs  [10] = '{32'd1, 32'h1f, 32'hffffffff, 32'd1, 32'd1,
                                  32'h24, 32'd4, 32'h0ff00ff0, 32'h12345000, 32'h0ff0_ff00};
        logic [31:0] exp [10] = '{32'h80000000, 32'hffffffff, 32'd1, 32'd1, 32'hffffffff,
                                  32'h10, 32'h08000000, 32'hf0f0f0f0, 32'h12345000, 32'h00f0_1200};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ops[i], as[i], bs[i], 32'd0);
            tick();
            checks++;
            if (aluResultE !== exp[i] || regWriteEnE !== 1'b1) begin
                errors++;
                $display("FAIL alu_%0d op=%0d: res=%h rw=%b expected %h 1", i, ops[i],
                         aluResultE, regWriteEnE, exp[i]);
            end
        end
        drive(1'b0, 1'b1, 2'd0, 1'b1, MEM_SW, ALU_ADD, 32'd5, 32'd5, 32'd9);
        tick();
        checks++;
        if (regWriteEnE !== 1'b0 || memWriteEnE !== 1'b0 || memOpTypeE !== NO_MEM ||
            aluResultE !== 32'd0) begin
            errors++;
            $display("FAIL invalid_bubble: rw=%b mw=%b mop=%h res=%h", regWriteEnE, memWriteEnE,
                     memOpTypeE, aluResultE);
        end
        drive(1'b1, 1'b1, 2'd0, 1'b0, MEM_LB, ALU_ADD, 32'd5, 32'd5, 32'd9);
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        checks++;
        if (regWriteEnE !== 1'b0 || memOpTypeE !== NO_MEM || aluResultE !== 32'd0) begin
            errors++;
            $display("FAIL flush_bubble: rw=%b mop=%h res=%h", regWriteEnE, memOpTypeE, aluResultE);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 1'b0, 2'd0, 1'b1, MEM_SW, ALU_ADD, 32'h80000000, 32'd0, 32'haaaaaaaa);
        tick();
        checks++;
        if (memWriteEnE !== 1'b1 || regWriteEnE !== 1'b0 || memOpTypeE !== MEM_SW ||
            aluResultE !== 32'h80000000 || memWriteDataE !== 32'haaaaaaaa) begin
            errors++;
            $display("FAIL store: mw=%b rw=%b mop=%h addr=%h data=%h expected 1 0 7 80000000 aaaaaaaa",
                     memWriteEnE, regWriteEnE, memOpTypeE, aluResultE, memWriteDataE);
        end
    endtask

    task automatic test_mulhu_back_to_back();
        int n, leaks;
        drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ALU_MULHU, 32'hffffffff, 32'hffffffff, 32'd0);
        tick();
        drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd5, 32'd6, 32'd0);
        wait_stall(n, leaks);
        checks++;
        if (n !== 33 || leaks !== 0) begin
            errors++;
            $display("FAIL mulhu_stall: cycles=%0d leaks=%0d expected 33 0", n, leaks);
        end
        checks++;
        if (aluResultE !== 32'hfffffffe || regWriteEnE !== 1'b1 || mulBusyE !== 1'b1) begin
            errors++;
            $display("FAIL mulhu_result: res=%h rw=%b busy=%b expected fffffffe 1 1", aluResultE,
                     regWriteEnE, mulBusyE);
        end
        tick();
        checks++;
        if (aluResultE !== 32'd11 || regWriteEnE !== 1'b1 || stallD !== 1'b0 || mulBusyE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add: res=%h rw=%b stall=%b busy=%b expected 0000000b 1 0 0",
                     aluResultE, regWriteEnE, stallD, mulBusyE);
        end
    endtask

    task automatic test_mul_flush();
        int n, leaks;
        drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ALU_MUL, 32'h00010001, 32'h00010001, 32'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd0, 32'd0, 32'd0);
        wait_stall(n, leaks);
        checks++;
        if (n !== 33 || leaks !== 0 || aluResultE !== 32'h00020001 || regWriteEnE !== 1'b1) begin
            errors++;
            $display("FAIL mul_low: cycles=%0d leaks=%0d res=%h rw=%b expected 33 0 00020001 1",
                     n, leaks, aluResultE, regWriteEnE);
        end
        tick();
        drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ALU_MUL, 32'h00010001, 32'h00010001, 32'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd0, 32'd0, 32'd0);
        leaks = 0;
        for (int i = 0; i < 11; i++) begin
            if (regWriteEnE) leaks++;
            tick();
        end
        checks++;
        if (stallD !== 1'b1 || mulBusyE !== 1'b1) begin
            errors++;
            $display("FAIL mul_running: stall=%b busy=%b expected 1 1", stallD, mulBusyE);
        end
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        checks++;
        if (stallD !== 1'b0 || mulBusyE !== 1'b0 || regWriteEnE !== 1'b0 || aluResultE !== 32'd0) begin
            errors++;
            $display("FAIL mul_flush: stall=%b busy=%b rw=%b res=%h expected 0 0 0 0", stallD,
                     mulBusyE, regWriteEnE, aluResultE);
        end
        for (int i = 0; i < 40; i++) begin
            if (regWriteEnE || stallD) leaks++;
            tick();
        end
        checks++;
        if (leaks !== 0) begin
            errors++;
            $display("FAIL mul_flush_leak: leaks=%0d expected 0", leaks);
        end
    endtask

    task automatic test_mul_reset();
        int n, leaks;
        drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ALU_MUL, 32'hffff_ffff, 32'h1234_5678, 32'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (stallD !== 1'b0 || mulBusyE !== 1'b0 || regWriteEnE !== 1'b0 || aluResultE !== 32'd0) begin
            errors++;
            $display("FAIL mul_reset: stall=%b busy=%b rw=%b res=%h expected 0 0 0 0", stallD,
                     mulBusyE, regWriteEnE, aluResultE);
        end
        reset = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 1'b0, NO_MEM, ALU_MUL, 32'd3, 32'd7, 32'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, NO_MEM, ALU_ADD, 32'd0, 32'd0, 32'd0);
        wait_stall(n, leaks);
        checks++;
        if (n !== 33 || leaks !== 0 || aluResultE !== 32'd21 || regWriteEnE !== 1'b1) begin
            errors++;
            $display("FAIL mul_after_reset: cycles=%0d leaks=%0d res=%h rw=%b expected 33 0 00000015 1",
                     n, leaks, aluResultE, regWriteEnE);
        end
        tick();
        checks++;
        if (regWriteEnE !== 1'b0 || mulBusyE !== 1'b0) begin
            errors++;
            $display("FAIL mul_single_emit: rw=%b busy=%b expected 0 0", regWriteEnE, mulBusyE);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_mulhu_back_to_back();
        test_mul_flush();
        test_mul_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
